rv32_ex_delay_pipe: RTL and testbench
=====================================

Name: rv32_ex_delay_pipe

Overview:
- Parametrised multi-stage delay pipeline carrying instruction word, PC and per-unit control fields from EX toward later execute stages.
- Generalises the fixed two-flop EX→EX2 delay:
  - configurable depth;
  - per-stage valid tracking;
  - global stall (hold);
  - flush of every in-flight stage, not only the entry stage;
  - defined reset state.
- Sits between the EX decode/control outputs and the EX2..EXn consumers.

Parameters:
- DEPTH, 2, number of register stages (1..8); input-to-output latency in cycles.
- XLEN, 32, width of code and PC fields.
- ALU_W, 5, ALU control width {EN, OpSel[3:0]}.
- BSH_W, 4, barrel-shift control width {EN, Logical, Direction, Immediate}.
- PCC_W, 5, PC control width {EN, OpSel[2:0], Normal_Op}.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold all stages.
- flush  in  1  kill all in-flight entries.
- valid_in  in  1  entry stage receives a real instruction.
- code_in  in  XLEN  instruction word.
- pc_in  in  XLEN  instruction PC.
- alu_in  in  ALU_W  ALU control.
- bshift_in  in  BSH_W  shifter control.
- pc_ctrl_in  in  PCC_W  PC control.
- valid_out  out  1  last stage holds a real instruction.
- code_out  out  XLEN  delayed code.
- pc_out  out  XLEN  delayed PC.
- alu_out  out  ALU_W  delayed ALU control.
- bshift_out  out  BSH_W  delayed shifter control.
- pc_ctrl_out  out  PCC_W  delayed PC control.

Behaviour:
- Storage: DEPTH stages s[0..DEPTH-1]; each holds {valid, code, pc, alu, bshift, pc_ctrl}. Outputs drive directly from s[DEPTH-1], with no extra output flop.
- NOP bundle:
  - valid=0, code=32'h0000_0013 (ADDI x0,x0,0), pc=0;
  - alu={0,4'd7}, bshift=4'b0000, pc_ctrl={1,3'd0,1}.
- Reset (rst=1 at edge): every stage loads the NOP bundle. After reset, outputs equal the NOP bundle with valid_out=0.
- Priority per edge: rst > flush > stall > advance.
- flush=1: every stage loads the NOP bundle in the same edge, including entries that were stalled. The input presented that cycle is discarded.
- stall=1 (no flush): all stages hold their values; inputs are ignored.
- Advance: s[0] <= inputs, with valid=valid_in; s[k] <= s[k-1] for k ≥ 1.
- Input-field handling when valid_in=0:
  - code, alu, bshift and pc_ctrl are replaced by the NOP bundle values;
  - pc is still captured, for debug.
- Latency: an instruction accepted at edge t appears on the outputs after edge t+DEPTH-1, i.e. it is visible DEPTH cycles after it was presented, with no stalls. Each stall cycle adds exactly one cycle.
- DEPTH=1: a single stage; the behaviour rules above are unchanged.
- Other: no back-pressure output; no combinational paths from input to output.

Optional Feature:
- Macro: RV32_DELAY_PERF_EN.
- When defined:
  - adds output ports `bubble_cnt [15:0]` and `flush_kill_cnt [15:0]`;
  - both counters reset to 0 on rst.
  - bubble_cnt increments on each non-stalled edge where valid_out=0.
  - flush_kill_cnt adds the number of valid stages destroyed by each flush (popcount of stage valids, 0..DEPTH).
  - Both counters saturate at 16'hFFFF.
- When undefined: the ports and logic are absent; pipeline behaviour is identical.

Decomposition:
- Shared package rv32_pipe_pkg holds:
  - localparams NOP_CODE=32'h0000_0013, NOP_ALU=5'b0_0111, NOP_BSHIFT=4'b0000, NOP_PC_CTRL=5'b1_000_1;
  - field-width localparams.
- Sub-module rv32_delay_stage: one stage register with load/hold/nop-load controls. It is instantiated DEPTH times in a generate loop.
- The top level owns the priority decode and the optional perf counters.

Test Plan:
- Reset then idle, DEPTH=2: assert rst 2 cycles → valid_out=0, code_out=32'h00000013, alu_out=5'h07, pc_ctrl_out=5'h11, pc_out=0.
- Streaming, DEPTH=3: issue code=A0..A4 with valid_in=1 and pc=0x100+4i on consecutive cycles → A0/0x100 appears 3 cycles after issue, then one per cycle in order.
- Stall mid-stream, DEPTH=2: stall=1 for 2 cycles while A1 is in s[1] → outputs hold A1 for 3 cycles; A2 follows; no loss or duplication.
- Flush with full pipe, DEPTH=4: four valid entries, then flush=1 for 1 cycle → next cycle valid_out=0 with the NOP bundle. Instructions issued after the flush emerge after 4 cycles. With RV32_DELAY_PERF_EN, flush_kill_cnt=4.
- Flush and stall together: flush=1, stall=1 → flush wins; all stages become NOP. rst asserted in the same cycle as flush → reset state, with counters 0.
- valid_in=0 bubble, DEPTH=2: present code=0xDEADBEEF with valid_in=0 → code_out=0x00000013 and valid_out=0 at the corresponding output cycle. With perf enabled, bubble_cnt increments by 1.

Source files
------------

// File: rtl/rv32_pipe_pkg.sv
// rv32_pipe_pkg
// Shared definitions for the EX delay pipeline: default field widths,
// the NOP bundle contents (ADDI x0,x0,0 with its matching control fields)
// and a saturating add used by the optional performance counters
// (enabled in the top level with RV32_DELAY_PERF_EN).
package rv32_pipe_pkg;

  localparam int RV32_XLEN  = 32;
  localparam int RV32_ALU_W = 5;
  localparam int RV32_BSH_W = 4;
  localparam int RV32_PCC_W = 5;

  localparam logic [31:0] NOP_CODE    = 32'h0000_0013;
  localparam logic [4:0]  NOP_ALU     = 5'b0_0111;
  localparam logic [3:0]  NOP_BSHIFT  = 4'b0000;
  localparam logic [4:0]  NOP_PC_CTRL = 5'b1_000_1;

  // 16-bit counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] inc);
    logic [16:0] sum;
    sum = {1'b0, a} + {13'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/rv32_delay_stage.sv
// rv32_delay_stage
// One register stage of the EX delay pipeline.
// Ports:
//   clk, rst        clock and synchronous active-high reset (loads NOP)
//   load            capture the *_i bundle this edge
//   nop_load        load the NOP bundle this edge (overrides load)
//   valid_i..pcc_i  incoming bundle
//   valid_o..pcc_o  registered bundle
// With neither load nor nop_load the stage holds its contents.
module rv32_delay_stage
  import rv32_pipe_pkg::*;
#(
  parameter int XLEN  = RV32_XLEN,
  parameter int ALU_W = RV32_ALU_W,
  parameter int BSH_W = RV32_BSH_W,
  parameter int PCC_W = RV32_PCC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             nop_load,
  input  logic             valid_i,
  input  logic [XLEN-1:0]  code_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [ALU_W-1:0] alu_i,
  input  logic [BSH_W-1:0] bsh_i,
  input  logic [PCC_W-1:0] pcc_i,
  output logic             valid_o,
  output logic [XLEN-1:0]  code_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [ALU_W-1:0] alu_o,
  output logic [BSH_W-1:0] bsh_o,
  output logic [PCC_W-1:0] pcc_o
);

  logic             valid_q, valid_d;
  logic [XLEN-1:0]  code_q,  code_d;
  logic [XLEN-1:0]  pc_q,    pc_d;
  logic [ALU_W-1:0] alu_q,   alu_d;
  logic [BSH_W-1:0] bsh_q,   bsh_d;
  logic [PCC_W-1:0] pcc_q,   pcc_d;

  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    pc_d    = pc_q;
    alu_d   = alu_q;
    bsh_d   = bsh_q;
    pcc_d   = pcc_q;
    if (nop_load) begin
      valid_d = 1'b0;
      code_d  = XLEN'(NOP_CODE);
      pc_d    = '0;
      alu_d   = ALU_W'(NOP_ALU);
      bsh_d   = BSH_W'(NOP_BSHIFT);
      pcc_d   = PCC_W'(NOP_PC_CTRL);
    end else if (load) begin
      valid_d = valid_i;
      code_d  = code_i;
      pc_d    = pc_i;
      alu_d   = alu_i;
      bsh_d   = bsh_i;
      pcc_d   = pcc_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      code_q  <= XLEN'(NOP_CODE);
      pc_q    <= '0;
      alu_q   <= ALU_W'(NOP_ALU);
      bsh_q   <= BSH_W'(NOP_BSHIFT);
      pcc_q   <= PCC_W'(NOP_PC_CTRL);
    end else begin
      valid_q <= valid_d;
      code_q  <= code_d;
      pc_q    <= pc_d;
      alu_q   <= alu_d;
      bsh_q   <= bsh_d;
      pcc_q   <= pcc_d;
    end
  end

  assign valid_o = valid_q;
  assign code_o  = code_q;
  assign pc_o    = pc_q;
  assign alu_o   = alu_q;
  assign bsh_o   = bsh_q;
  assign pcc_o   = pcc_q;

endmodule

// File: rtl/rv32_ex_delay_pipe.sv
// rv32_ex_delay_pipe
// DEPTH-stage delay pipeline carrying code, PC and ALU / barrel-shift /
// PC control fields from EX to the later execute stages.
// Ports:
//   clk, rst        clock, synchronous active-high reset (all stages NOP)
//   stall           hold every stage, input ignored
//   flush           load NOP into every stage, input discarded
//   valid_in, code_in, pc_in, alu_in, bshift_in, pc_ctrl_in   entry bundle
//   valid_out, code_out, pc_out, alu_out, bshift_out, pc_ctrl_out
//                   contents of the last stage (no extra output flop)
// Optional (macro RV32_DELAY_PERF_EN):
//   bubble_cnt      non-stalled edges with valid_out low, saturating
//   flush_kill_cnt  valid entries destroyed by flushes, saturating
// Priority per edge: rst > flush > stall > advance.
module rv32_ex_delay_pipe
  import rv32_pipe_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = RV32_XLEN,
  parameter int ALU_W = RV32_ALU_W,
  parameter int BSH_W = RV32_BSH_W,
  parameter int PCC_W = RV32_PCC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [XLEN-1:0]  code_in,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [ALU_W-1:0] alu_in,
  input  logic [BSH_W-1:0] bshift_in,
  input  logic [PCC_W-1:0] pc_ctrl_in,
  output logic             valid_out,
  output logic [XLEN-1:0]  code_out,
  output logic [XLEN-1:0]  pc_out,
  output logic [ALU_W-1:0] alu_out,
  output logic [BSH_W-1:0] bshift_out,
  output logic [PCC_W-1:0] pc_ctrl_out
`ifdef RV32_DELAY_PERF_EN
  ,
  output logic [15:0]      bubble_cnt,
  output logic [15:0]      flush_kill_cnt
`endif
);

  // Chain index 0 is the entry bundle; index k+1 is the output of stage k.
  logic [DEPTH:0]   vld_c;
  logic [XLEN-1:0]  code_c [DEPTH+1];
  logic [XLEN-1:0]  pc_c   [DEPTH+1];
  logic [ALU_W-1:0] alu_c  [DEPTH+1];
  logic [BSH_W-1:0] bsh_c  [DEPTH+1];
  logic [PCC_W-1:0] pcc_c  [DEPTH+1];

  // A bubble carries NOP control fields, but its PC is kept for debug.
  assign vld_c[0]  = valid_in;
  assign code_c[0] = valid_in ? code_in    : XLEN'(NOP_CODE);
  assign pc_c[0]   = pc_in;
  assign alu_c[0]  = valid_in ? alu_in     : ALU_W'(NOP_ALU);
  assign bsh_c[0]  = valid_in ? bshift_in  : BSH_W'(NOP_BSHIFT);
  assign pcc_c[0]  = valid_in ? pc_ctrl_in : PCC_W'(NOP_PC_CTRL);

  // rst is handled inside each stage; flush beats stall.
  logic stage_load;
  logic stage_nop;
  assign stage_nop  = flush;
  assign stage_load = ~stall;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    rv32_delay_stage #(
      .XLEN (XLEN),
      .ALU_W(ALU_W),
      .BSH_W(BSH_W),
      .PCC_W(PCC_W)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .load    (stage_load),
      .nop_load(stage_nop),
      .valid_i (vld_c[k]),
      .code_i  (code_c[k]),
      .pc_i    (pc_c[k]),
      .alu_i   (alu_c[k]),
      .bsh_i   (bsh_c[k]),
      .pcc_i   (pcc_c[k]),
      .valid_o (vld_c[k+1]),
      .code_o  (code_c[k+1]),
      .pc_o    (pc_c[k+1]),
      .alu_o   (alu_c[k+1]),
      .bsh_o   (bsh_c[k+1]),
      .pcc_o   (pcc_c[k+1])
    );
  end

  assign valid_out   = vld_c[DEPTH];
  assign code_out    = code_c[DEPTH];
  assign pc_out      = pc_c[DEPTH];
  assign alu_out     = alu_c[DEPTH];
  assign bshift_out  = bsh_c[DEPTH];
  assign pc_ctrl_out = pcc_c[DEPTH];

`ifdef RV32_DELAY_PERF_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic [15:0] flush_kill_cnt_q, flush_kill_cnt_d;
  logic [3:0]  kill_num;

  always_comb begin
    kill_num = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      kill_num = kill_num + 4'(vld_c[k]);
    end
    bubble_cnt_d     = bubble_cnt_q;
    flush_kill_cnt_d = flush_kill_cnt_q;
    if (!stall && !vld_c[DEPTH]) begin
      bubble_cnt_d = sat_add16(bubble_cnt_q, 4'd1);
    end
    if (flush) begin
      flush_kill_cnt_d = sat_add16(flush_kill_cnt_q, kill_num);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q     <= '0;
      flush_kill_cnt_q <= '0;
    end else begin
      bubble_cnt_q     <= bubble_cnt_d;
      flush_kill_cnt_q <= flush_kill_cnt_d;
    end
  end

  assign bubble_cnt     = bubble_cnt_q;
  assign flush_kill_cnt = flush_kill_cnt_q;
`endif

endmodule

// File: tb/tb_rv32_ex_delay_pipe.sv
// Testbench for rv32_ex_delay_pipe (default build, DEPTH=3).
// Reference model: a queue of in-flight bundles, each tagged with the stage
// it currently occupies. Advancing edges age every entry and append the new
// one; rst/flush empty the queue. An entry aged DEPTH-1 is what the outputs
// must show; with no such entry the outputs must show the reset NOP bundle.
module tb_rv32_ex_delay_pipe;

  localparam int D = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0, stall = 1'b0, flush = 1'b0, valid_in = 1'b0;
  logic [31:0] code_in = '0, pc_in = '0;
  logic [4:0]  alu_in = '0, pc_ctrl_in = '0;
  logic [3:0]  bshift_in = '0;
  logic        valid_out;
  logic [31:0] code_out, pc_out;
  logic [4:0]  alu_out, pc_ctrl_out;
  logic [3:0]  bshift_out;

  always #5 clk = ~clk;

  rv32_ex_delay_pipe #(.DEPTH(D)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .valid_in(valid_in), .code_in(code_in), .pc_in(pc_in),
    .alu_in(alu_in), .bshift_in(bshift_in), .pc_ctrl_in(pc_ctrl_in),
    .valid_out(valid_out), .code_out(code_out), .pc_out(pc_out),
    .alu_out(alu_out), .bshift_out(bshift_out), .pc_ctrl_out(pc_ctrl_out)
  );

  typedef struct {
    logic        v;
    logic [31:0] code;
    logic [31:0] pc;
    logic [4:0]  alu;
    logic [3:0]  bsh;
    logic [4:0]  pcc;
    int          age;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // Drive one cycle of stimulus, then update the reference model at the edge.
  task automatic step(input logic r, input logic s, input logic f, input logic v,
                      input logic [31:0] c, input logic [31:0] p,
                      input logic [4:0] a, input logic [3:0] b, input logic [4:0] pcc);
    ent_t e;
    @(negedge clk);
    rst = r; stall = s; flush = f; valid_in = v;
    code_in = c; pc_in = p; alu_in = a; bshift_in = b; pc_ctrl_in = pcc;
    @(posedge clk);
    if (r || f) begin
      q.delete();
    end else if (!s) begin
      if (q.size() > 0 && q[0].age == D - 1) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      e.v    = v;
      e.code = v ? c   : 32'h0000_0013;
      e.pc   = p;
      e.alu  = v ? a   : 5'h07;
      e.bsh  = v ? b   : 4'h0;
      e.pcc  = v ? pcc : 5'h11;
      e.age  = 0;
      q.push_back(e);
    end
    if (r) mon_en = 1'b1;
  endtask

  task automatic issue(input logic [31:0] c, input logic [31:0] p);
    step(1'b0, 1'b0, 1'b0, 1'b1, c, p, 5'($urandom), 4'($urandom), 5'($urandom));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0, 4'h0, 5'h0);
  endtask

  // Monitor: after every edge compare the whole output bundle.
  initial begin
    logic [78:0] act, exp_b;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (q.size() > 0 && q[0].age == D - 1)
          exp_b = {q[0].v, q[0].code, q[0].pc, q[0].alu, q[0].bsh, q[0].pcc};
        else
          exp_b = {1'b0, 32'h0000_0013, 32'h0, 5'h07, 4'h0, 5'h11};
        act = {valid_out, code_out, pc_out, alu_out, bshift_out, pc_ctrl_out};
        checks++;
        if (act !== exp_b) begin
          errors++;
          $display("FAIL out_bundle t=%0t got v=%b code=%h pc=%h alu=%h bsh=%h pcc=%h want v=%b code=%h pc=%h alu=%h bsh=%h pcc=%h",
                   $time, act[78], act[77:46], act[45:14], act[13:9], act[8:5], act[4:0],
                   exp_b[78], exp_b[77:46], exp_b[45:14], exp_b[13:9], exp_b[8:5], exp_b[4:0]);
        end
      end
    end
  end

  initial begin
    int n;
    // reset, then idle
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h44, 5'h1F, 4'hF, 5'h1F);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0, 4'h0, 5'h0);
    repeat (2) idle();

    // streaming
    for (int i = 0; i < 5; i++) issue(32'hA0 + i, 32'h100 + 4 * i);
    repeat (D) idle();

    // stall mid-stream, two cycles
    for (int i = 0; i < 3; i++) issue(32'hB0 + i, 32'h200 + 4 * i);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'hBAD0, 32'h0, 5'h3, 4'h3, 5'h3);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'hBAD1, 32'h0, 5'h3, 4'h3, 5'h3);
    for (int i = 3; i < 5; i++) issue(32'hB0 + i, 32'h200 + 4 * i);
    repeat (D) idle();

    // flush with a full pipe; input that cycle is discarded
    for (int i = 0; i < D; i++) issue(32'hC0 + i, 32'h300 + 4 * i);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'hBAD2, 32'h9, 5'h1, 4'h1, 5'h1);
    idle();

    // flush together with stall: flush wins
    for (int i = 0; i < 2; i++) issue(32'hD0 + i, 32'h400 + 4 * i);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'hBAD3, 32'h9, 5'h1, 4'h1, 5'h1);
    idle();

    // rst together with flush
    for (int i = 0; i < 2; i++) issue(32'hE0 + i, 32'h500 + 4 * i);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'hBAD4, 32'h9, 5'h1, 4'h1, 5'h1);

    // bubble: code/control replaced by NOP, pc kept
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h600, 5'h1A, 4'hA, 5'h0A);
    issue(32'hF0, 32'h604);
    repeat (D) idle();

    // latency from a clean pipe
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 5'h0, 4'h0, 5'h0);
    issue(32'h1234_5678, 32'h700);
    #1;
    n = 1;
    while (!valid_out && n < 20) begin
      idle();
      #1;
      n++;
    end
    checks++;
    if (n != D) begin
      errors++;
      $display("FAIL latency got=%0d want=%0d", n, D);
    end
    repeat (D) idle();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 99) < 1), 1'($urandom_range(0, 99) < 20),
           1'($urandom_range(0, 99) < 5), 1'($urandom_range(0, 99) < 75),
           $urandom, $urandom, 5'($urandom), 4'($urandom), 5'($urandom));
    end
    repeat (D + 1) idle();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
